mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencer for a single signed 8x8 -> 16-bit pipelined MAC unit: runs one dot product of runtime length len over two operand memories.
- Per job: clears the MAC accumulator, streams operand pairs into it, counts returned valid_out pulses, captures the final accumulator value and signals completion.
- Sits between the layer-level scheduler (start/done handshake) and one MAC instance plus its two operand RAMs.

Parameters:
- MAX_LEN, 64, maximum vector length.
- ADDR_W, 6, operand RAM address width; must be ≥ clog2(MAX_LEN).
- TIMEOUT, 16, max cycles in DRAIN without a mac_valid_out pulse before error.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  job request; sampled in IDLE only.
- len  in  ADDR_W+1  vector length, 0..MAX_LEN; latched on accepted start.
- hold  in  1  stall request from operand supplier; pauses issuing.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse, job finished.
- err  out  1  sticky timeout flag; cleared on next accepted start.
- result  out  16  signed final dot product; held until next done.
- rd_en  out  1  operand RAM read enable (A and B together).
- rd_addr  out  ADDR_W  operand RAM read address.
- a_rdata  in  8  signed A operand; 1-cycle read latency.
- b_rdata  in  8  signed B operand; 1-cycle read latency.
- mac_clr  out  1  drives MAC synchronous reset.
- mac_a  out  8  signed; combinational from a_rdata.
- mac_b  out  8  signed; combinational from b_rdata.
- mac_valid_in  out  1  registered copy of rd_en.
- mac_f  in  16  signed MAC accumulator.
- mac_valid_out  in  1  MAC result-valid pulse, one per accepted operand pair.

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, err=0, result=0, rd_en=0, rd_addr=0, mac_clr=1, mac_valid_in=0, all counters 0.
- States: IDLE, CLEAR, ISSUE, DRAIN, FINISH.
- IDLE:
  - mac_clr=1.
  - start=1 -> latch len, clear err, busy=1.
  - Go to FINISH if len==0, else CLEAR.
  - len>MAX_LEN is saturated to MAX_LEN.
- CLEAR: exactly one cycle with mac_clr=1, issue_cnt=0, ret_cnt=0 -> ISSUE.
- ISSUE:
  - mac_clr=0.
  - Each cycle with hold=0: rd_en=1, rd_addr=issue_cnt, issue_cnt++.
  - hold=1: rd_en=0, counter frozen.
  - Last read (issue_cnt==len-1, hold=0) -> DRAIN.
- mac_valid_in:
  - Equals rd_en delayed one cycle, so it aligns with a_rdata/b_rdata.
  - Continues correctly across the ISSUE->DRAIN boundary.
- ret_cnt increments on every mac_valid_out=1 in CLEAR/ISSUE/DRAIN. Returns overlap issuing.
- DRAIN:
  - When mac_valid_out=1 and ret_cnt==len-1: result<=mac_f, go to FINISH. mac_f is already updated in the valid_out cycle.
  - Watchdog counts cycles without mac_valid_out. Reaching TIMEOUT: err=1, result<=mac_f, go to FINISH.
- FINISH:
  - done=1 for one cycle, busy=0 next cycle, mac_clr=1 -> IDLE.
  - For len==0, result=0.
- start while busy: ignored, no queueing.
- Arithmetic: signed two's complement, 16-bit wrap. No saturation; the controller does not modify mac_f.
- Expected MAC valid_in -> valid_out latency is 3 cycles. Correctness relies only on pulse counting, not on that latency.
- Reset mid-job: immediate return to reset values; the MAC is cleared via mac_clr=1.

Decomposition:
- Package mac_ctrl_pkg:
  - state enum typedef.
  - Widths: DATA_W=8, ACC_W=16.
  - Default MAX_LEN and TIMEOUT constants.
- One sub-module, mac_watchdog: loadable down-counter with expire pulse, restarted by mac_valid_out.
- Top instantiates the controller only; MAC and RAMs stay outside, connected at the layer level.

Test Plan:
- len=4, A=[1,2,3,4], B=[5,6,7,8], hold=0, MAC model at 3-cycle latency -> result=70, err=0. done exactly once; busy high from start+1 to done.
- len=2, A=[-128,-128], B=[-128,-128] -> result=16'sh8000 (32768 wraps to -32768), err=0.
- len=5, A=B=[1,1,1,1,1], hold high for 3 cycles after the 2nd read -> exactly 5 rd_en pulses with addrs 0..4 in order. mac_valid_in tracks rd_en+1; result=5.
- len=0 start -> no rd_en, done one pulse 2 cycles after start, result=0. Back-to-back start on the cycle after done is accepted.
- len=3, MAC model drops the 3rd valid_out -> err=1 after TIMEOUT=16 idle cycles, done pulses, result=partial sum. Next start clears err.
- reset asserted mid-ISSUE at len=8 -> outputs at reset values within the same cycle. A new start with len=2, A=[3,4], B=[2,2] -> result=14 (no stale accumulation).

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// rtl/mac_ctrl_pkg.sv - shared types and constants for the MAC sequencer
package mac_ctrl_pkg;

    localparam int DATA_W      = 8;
    localparam int ACC_W       = 16;
    localparam int DEF_MAX_LEN = 64;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/mac_watchdog.sv
// rtl/mac_watchdog.sv - loadable down-counter that pulses expire after TIMEOUT idle cycles
module mac_watchdog
    import mac_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= LOAD_VAL;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Fires on the TIMEOUT-th consecutive enabled cycle without a reload.
    assign expire = en && !load && (cnt == CNT_W'(1));

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - dot-product sequencer driving one pipelined MAC and its operand RAMs
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W:0]          len,
    input  logic                     hold,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [ACC_W-1:0]         result,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        a_rdata,
    input  logic [DATA_W-1:0]        b_rdata,
    output logic                     mac_clr,
    output logic [DATA_W-1:0]        mac_a,
    output logic [DATA_W-1:0]        mac_b,
    output logic                     mac_valid_in,
    input  logic [ACC_W-1:0]         mac_f,
    input  logic                     mac_valid_out
);

    localparam logic [ADDR_W:0] MAX_LEN_W = (ADDR_W + 1)'(MAX_LEN);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     issue_cnt;
    logic [ADDR_W:0]     ret_cnt;
    logic                busy_q;
    logic                err_q;
    logic [ACC_W-1:0]    result_q;
    logic                vin_q;
    logic [ADDR_W:0]     len_sat;
    logic [ADDR_W:0]     len_m1;
    logic                last_issue;
    logic                last_ret;
    logic                all_ret;
    logic                wd_load;
    logic                wd_en;
    logic                wd_expire;

    assign len_sat    = (len > MAX_LEN_W) ? MAX_LEN_W : len;
    assign len_m1     = len_q - 1'b1;
    assign last_issue = (issue_cnt == len_m1);
    assign last_ret   = mac_valid_out && (ret_cnt == len_m1);
    // Covers a MAC fast enough to return every pulse before issuing ends.
    assign all_ret    = (ret_cnt == len_q);

    assign wd_en   = (state_q == ST_DRAIN);
    assign wd_load = !wd_en || mac_valid_out;

    mac_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .load   (wd_load),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len_sat == '0) ? ST_FINISH : ST_CLEAR;
                end
            end
            ST_CLEAR:  state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (!hold && last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_ret || all_ret || wd_expire) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mac_clr = 1'b0;
        rd_en   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE:   mac_clr = 1'b1;
            ST_CLEAR:  mac_clr = 1'b1;
            ST_ISSUE:  rd_en   = !hold;
            ST_DRAIN:  mac_clr = 1'b0;
            ST_FINISH: begin
                mac_clr = 1'b1;
                done    = 1'b1;
            end
            default:   mac_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
            vin_q     <= 1'b0;
        end else begin
            vin_q <= rd_en;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q  <= len_sat;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (len_sat == '0) begin
                            result_q <= '0;
                        end
                    end
                end
                ST_CLEAR: begin
                    issue_cnt <= '0;
                    ret_cnt   <= '0;
                end
                ST_ISSUE: begin
                    if (rd_en) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    if (mac_valid_out) begin
                        ret_cnt <= ret_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (mac_valid_out) begin
                        ret_cnt <= ret_cnt + 1'b1;
                    end
                    // mac_f already includes the pair returned this cycle.
                    if (last_ret || all_ret) begin
                        result_q <= mac_f;
                    end else if (wd_expire) begin
                        err_q    <= 1'b1;
                        result_q <= mac_f;
                    end
                end
                ST_FINISH: busy_q <= 1'b0;
                default:   busy_q <= 1'b0;
            endcase
        end
    end

    assign busy         = busy_q;
    assign err          = err_q;
    assign result       = result_q;
    assign rd_addr      = issue_cnt[ADDR_W-1:0];
    assign mac_valid_in = vin_q;
    assign mac_a        = a_rdata;
    assign mac_b        = b_rdata;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - directed self-checking bench for mac_seq_ctrl with RAM and 3-stage MAC models
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  len;
    logic        hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] result;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [7:0]  a_rdata = '0;
    logic [7:0]  b_rdata = '0;
    logic        mac_clr;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic        mac_valid_in;
    logic [15:0] mac_f;
    logic        mac_valid_out;

    mac_seq_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .len           (len),
        .hold          (hold),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .result        (result),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .a_rdata       (a_rdata),
        .b_rdata       (b_rdata),
        .mac_clr       (mac_clr),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid_in  (mac_valid_in),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];

    always @(posedge clk) begin
        if (rd_en) begin
            a_rdata <= mem_a[rd_addr];
            b_rdata <= mem_b[rd_addr];
        end
    end

    // MAC model: valid_in at cycle t gives valid_out and updated accumulator at t+3.
    logic               v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    logic signed [15:0] p1 = '0, p2 = '0, acc = '0;
    int                 pair_n = 0;
    int                 drop_at = 0;

    always @(posedge clk) begin
        if (mac_clr) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            p1 <= '0;   p2 <= '0;   acc <= '0;
            pair_n <= 0;
        end else begin
            v1 <= mac_valid_in;
            p1 <= 16'($signed(mac_a)) * 16'($signed(mac_b));
            v2 <= v1;
            p2 <= p1;
            v3 <= 1'b0;
            if (v2) begin
                pair_n <= pair_n + 1;
                if (pair_n + 1 != drop_at) begin
                    v3  <= 1'b1;
                    acc <= acc + p2;
                end
            end
        end
    end

    assign mac_valid_out = v3;
    assign mac_f         = acc;

    int   tick = 0;
    int   done_cnt = 0;
    int   vi_bad = 0;
    logic rd_prev = 1'b0;
    int   rd_q [$];

    always @(posedge clk) tick <= tick + 1;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (rd_en) rd_q.push_back(int'(rd_addr));
        if (reset) begin
            rd_prev <= 1'b0;
        end else begin
            if (mac_valid_in !== rd_prev) vi_bad <= vi_bad + 1;
            rd_prev <= rd_en;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int t_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [6:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        t_acc = tick;
    endtask

    task automatic finish_job(input string tag, input int exp_lat, input logic [15:0] exp_res,
                              input logic exp_err, input int exp_reads);
        int n  = 0;
        int bb = 0;
        int ae = 0;
        do begin
            @(negedge clk);
            n++;
            if (!busy) bb++;
        end while (!done && n < 200);
        #1;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(tick - t_acc + 1), 32'(exp_lat));
        chk({tag, "_result"}, 32'(result), 32'(exp_res));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_busy_gap"}, 32'(bb), 32'd0);
        chk({tag, "_reads"}, 32'(rd_q.size()), 32'(exp_reads));
        foreach (rd_q[i]) if (rd_q[i] != i) ae++;
        chk({tag, "_addr_order"}, 32'(ae), 32'd0);
    endtask

    initial begin
        int dc0;
        reset = 1'b1;
        start = 1'b0;
        len   = '0;
        hold  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 8'd0;
            mem_b[i] = 8'd0;
        end

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_mac_clr", 32'(mac_clr), 32'd1);
        chk("rst_valid_in", 32'(mac_valid_in), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1*5+2*6+3*7+4*8 = 70
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = 8'(i + 5);
        end
        rd_q.delete();
        dc0 = done_cnt;
        start_job(7'd4);
        chk("t1_busy_after_start", 32'(busy), 32'd1);
        finish_job("t1", 10, 16'd70, 1'b0, 4);
        @(negedge clk); #1;
        chk("t1_done_low_after", 32'(done), 32'd0);
        chk("t1_busy_low_after", 32'(busy), 32'd0);
        chk("t1_done_pulses", 32'(done_cnt - dc0), 32'd1);

        // (-128*-128)*2 = 32768 wraps to 16'h8000
        mem_a[0] = 8'h80; mem_a[1] = 8'h80;
        mem_b[0] = 8'h80; mem_b[1] = 8'h80;
        rd_q.delete();
        start_job(7'd2);
        finish_job("t2", 8, 16'h8000, 1'b0, 2);

        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 8'd1;
            mem_b[i] = 8'd1;
        end
        rd_q.delete();
        start_job(7'd5);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        hold = 1'b1;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        hold = 1'b0;
        finish_job("t3_hold", 14, 16'd5, 1'b0, 5);
        chk("t3_valid_in_track", 32'(vi_bad), 32'd0);

        rd_q.delete();
        start_job(7'd0);
        finish_job("t4_len0", 1, 16'd0, 1'b0, 0);
        start_job(7'd1);
        finish_job("t4_b2b", 7, 16'd1, 1'b0, 1);

        rd_q.delete();
        start_job(7'd65);
        finish_job("t_sat", 70, 16'd64, 1'b0, 64);

        drop_at = 3;
        rd_q.delete();
        start_job(7'd3);
        finish_job("t5_timeout", 24, 16'd2, 1'b1, 3);
        drop_at = 0;
        rd_q.delete();
        start_job(7'd2);
        chk("t5_err_cleared", 32'(err), 32'd0);
        finish_job("t5_next", 8, 16'd2, 1'b0, 2);

        rd_q.delete();
        start_job(7'd8);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        chk("t6_rd_en_before_rst", 32'(rd_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rd_en", 32'(rd_en), 32'd0);
        chk("t6_rd_addr", 32'(rd_addr), 32'd0);
        chk("t6_mac_clr", 32'(mac_clr), 32'd1);
        chk("t6_valid_in", 32'(mac_valid_in), 32'd0);
        chk("t6_result", 32'(result), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_a[0] = 8'd3; mem_a[1] = 8'd4;
        mem_b[0] = 8'd2; mem_b[1] = 8'd2;
        rd_q.delete();
        start_job(7'd2);
        finish_job("t6_after_rst", 8, 16'd14, 1'b0, 2);
        chk("valid_in_track_all", 32'(vi_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
